// File: rtl/mem_port_arbiter_if.sv
// External io bus of the CPU top as seen by the fetch/data port arbiter.
// master = arbiter side, slave = memory/peripheral bus side.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] io_addr;
    logic              io_read;
    logic              io_write;
    logic              burst;
    logic [2:0]        burst_size;
    logic              read_ready;
    logic [DATA_W-1:0] io_wdata;
    logic [1:0]        io_byte_size;
    logic [DATA_W-1:0] io_rdata;
    logic              io_ready;

    modport master (
        output io_addr, io_read, io_write, burst, burst_size, read_ready,
               io_wdata, io_byte_size,
        input  io_rdata, io_ready
    );

    modport slave (
        input  io_addr, io_read, io_write, burst, burst_size, read_ready,
               io_wdata, io_byte_size,
        output io_rdata, io_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-beat io bus between instruction fetch and data load/store,
// with fetch starvation protection and a per-transaction bus timeout.
module mem_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_read_en,
    input  logic [DATA_W-1:0] inst_read_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_read_ready,
    input  logic              read_en,
    input  logic              write_en,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        byte_size,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_busy,
    output logic              mem_ready,
    mem_port_arbiter_if.master io,
    output logic              bus_err
);
    localparam logic [3:0] STREAK_MAX = STARVE_MAX[3:0];
    localparam logic [9:0] TMO_MAX    = TIMEOUT[9:0];

    typedef enum logic [1:0] {IDLE, INST, DATA, RESP} state_t;

    state_t            state, state_nxt;
    logic              grant_inst, grant_data, done, abort;
    logic              data_req;
    logic [3:0]        streak;
    logic [9:0]        tmo_cnt;
    logic [DATA_W-1:0] addr_q, wdata_q;
    logic [1:0]        size_q;
    logic              read_q, write_q;

    assign data_req = read_en | write_en;
    assign mem_busy = data_req & ~mem_ready;

    assign io.io_addr      = addr_q;
    assign io.io_wdata     = wdata_q;
    assign io.io_byte_size = size_q;
    assign io.io_read      = read_q;
    assign io.io_write     = write_q;
    assign io.read_ready   = read_q;
    assign io.burst        = 1'b0;
    assign io.burst_size   = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        grant_inst = 1'b0;
        grant_data = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                // Data normally wins; a saturated streak hands the bus to a waiting fetch.
                if (data_req && !(inst_read_en && streak == STREAK_MAX)) begin
                    grant_data = 1'b1;
                    state_nxt  = DATA;
                end else if (inst_read_en) begin
                    grant_inst = 1'b1;
                    state_nxt  = INST;
                end
            end
            INST, DATA: begin
                if (io.io_ready) begin
                    done      = 1'b1;
                    state_nxt = RESP;
                end else if (TIMEOUT != 0 && tmo_cnt == TMO_MAX) begin
                    abort     = 1'b1;
                    state_nxt = RESP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q          <= '0;
            wdata_q         <= '0;
            size_q          <= '0;
            read_q          <= 1'b0;
            write_q         <= 1'b0;
            streak          <= '0;
            tmo_cnt         <= '0;
            inst_rdata      <= '0;
            rdata           <= '0;
            inst_read_ready <= 1'b0;
            mem_ready       <= 1'b0;
            bus_err         <= 1'b0;
        end else begin
            inst_read_ready <= 1'b0;
            mem_ready       <= 1'b0;
            bus_err         <= 1'b0;
            if (grant_inst) begin
                addr_q  <= inst_read_addr;
                wdata_q <= '0;
                size_q  <= 2'b10;
                read_q  <= 1'b1;
                write_q <= 1'b0;
                streak  <= '0;
                tmo_cnt <= 10'd1;
            end else if (grant_data) begin
                addr_q  <= mem_addr;
                wdata_q <= wdata;
                size_q  <= byte_size;
                read_q  <= ~write_en;
                write_q <= write_en;
                if (streak != STREAK_MAX) streak <= streak + 4'd1;
                tmo_cnt <= 10'd1;
            end else if (done || abort) begin
                // Response registers load on entry to RESP so the pulse spans exactly that state.
                read_q  <= 1'b0;
                write_q <= 1'b0;
                tmo_cnt <= '0;
                bus_err <= abort;
                if (state == INST) begin
                    inst_read_ready <= 1'b1;
                    inst_rdata      <= (done && read_q) ? io.io_rdata : '0;
                end else begin
                    mem_ready <= 1'b1;
                    rdata     <= (done && read_q) ? io.io_rdata : '0;
                end
            end else if ((state == INST || state == DATA) && tmo_cnt != '1) begin
                tmo_cnt <= tmo_cnt + 10'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized fetch/data traffic against a transaction-level model of the
// arbitration, bus-hold, response and timeout rules.
module tb_mem_port_arbiter;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              inst_read_en;
    logic [DATA_W-1:0] inst_read_addr;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_read_ready;
    logic              read_en, write_en;
    logic [DATA_W-1:0] mem_addr, wdata;
    logic [1:0]        byte_size;
    logic [DATA_W-1:0] rdata;
    logic              mem_busy, mem_ready, bus_err;

    mem_port_arbiter_if #(.DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .inst_read_en(inst_read_en), .inst_read_addr(inst_read_addr),
        .inst_rdata(inst_rdata), .inst_read_ready(inst_read_ready),
        .read_en(read_en), .write_en(write_en), .mem_addr(mem_addr),
        .wdata(wdata), .byte_size(byte_size), .rdata(rdata),
        .mem_busy(mem_busy), .mem_ready(mem_ready),
        .io(bus), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Requester model: pending requests and the last word returned to each port.
    int                streak_m;
    logic              f_pend, d_pend, d_rd_en, d_wr_en;
    logic [DATA_W-1:0] f_addr, d_addr, d_wdata, last_inst, last_rdata;
    logic [1:0]        d_size;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_reqs();
        inst_read_en   = f_pend;
        inst_read_addr = f_addr;
        read_en        = d_pend & d_rd_en;
        write_en       = d_pend & d_wr_en;
        mem_addr       = d_addr;
        wdata          = d_wdata;
        byte_size      = d_size;
    endtask

    task automatic raise_reqs(input int p_f, input int p_d, input bit force_one);
        if (!f_pend && ($urandom_range(0, 99) < p_f || (force_one && !d_pend))) begin
            f_pend = 1'b1;
            f_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!d_pend && $urandom_range(0, 99) < p_d) begin
            int op = $urandom_range(0, 2);
            d_pend  = 1'b1;
            d_rd_en = (op != 1);
            d_wr_en = (op != 0);
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_size  = 2'($urandom_range(0, 3));
        end
        drive_reqs();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".io_read"},    bus.io_read, 0);
        check({tag, ".io_write"},   bus.io_write, 0);
        check({tag, ".burst"},      {bus.burst, bus.burst_size}, 0);
        check({tag, ".inst_ready"}, inst_read_ready, 0);
        check({tag, ".mem_ready"},  mem_ready, 0);
        check({tag, ".bus_err"},    bus_err, 0);
        check({tag, ".inst_rdata"}, inst_rdata, last_inst);
        check({tag, ".rdata"},      rdata, last_rdata);
        check({tag, ".mem_busy"},   mem_busy, d_pend);
    endtask

    task automatic run_txn(input int p_f, input int p_d);
        bit                to_data, abort, exp_wr;
        int                k, n, tries;
        logic [DATA_W-1:0] exp_addr, resp_word, exp_word;
        logic [1:0]        exp_size;
        @(negedge clk);
        check_quiet("idle");
        bus.io_ready = ($urandom_range(0, 1) == 1);
        bus.io_rdata = $urandom;
        tries = 0;
        raise_reqs(p_f, p_d, 1'b0);
        while (!f_pend && !d_pend) begin
            @(negedge clk);
            check_quiet("idle_wait");
            tries++;
            raise_reqs(p_f, p_d, tries >= 3);
        end

        to_data  = d_pend && !(f_pend && streak_m == STARVE_MAX);
        streak_m = to_data ? ((streak_m < STARVE_MAX) ? streak_m + 1 : STARVE_MAX) : 0;
        exp_addr = to_data ? d_addr : f_addr;
        exp_size = to_data ? d_size : 2'b10;
        exp_wr   = to_data && d_wr_en;
        k = $urandom_range(1, TIMEOUT + 2);
        if ($urandom_range(0, 3) == 0) k = TIMEOUT;
        abort = (k > TIMEOUT);
        n = abort ? TIMEOUT : k;
        resp_word = '0;

        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            check("bus.io_read",    bus.io_read, !exp_wr);
            check("bus.io_write",   bus.io_write, exp_wr);
            check("bus.read_ready", bus.read_ready, !exp_wr);
            check("bus.io_addr",    bus.io_addr, exp_addr);
            check("bus.io_size",    bus.io_byte_size, exp_size);
            if (exp_wr) check("bus.io_wdata", bus.io_wdata, d_wdata);
            check("bus.inst_ready", inst_read_ready, 0);
            check("bus.mem_ready",  mem_ready, 0);
            check("bus.mem_busy",   mem_busy, d_pend);
            check("bus.inst_hold",  inst_rdata, last_inst);
            check("bus.rdata_hold", rdata, last_rdata);
            bus.io_rdata = $urandom;
            bus.io_ready = (c == k);
            if (c == k) resp_word = bus.io_rdata;
        end

        @(negedge clk);
        exp_word = (abort || exp_wr) ? '0 : resp_word;
        if (to_data) last_rdata = exp_word;
        else         last_inst  = exp_word;
        check("resp.inst_ready", inst_read_ready, !to_data);
        check("resp.mem_ready",  mem_ready, to_data);
        check("resp.bus_err",    bus_err, abort);
        check("resp.io_read",    bus.io_read, 0);
        check("resp.io_write",   bus.io_write, 0);
        check("resp.inst_rdata", inst_rdata, last_inst);
        check("resp.rdata",      rdata, last_rdata);
        check("resp.mem_busy",   mem_busy, to_data ? 1'b0 : d_pend);
        if (to_data) d_pend = 1'b0;
        else         f_pend = 1'b0;
        drive_reqs();
        bus.io_ready = ($urandom_range(0, 1) == 1);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        check_quiet("pre_rst");
        f_pend = 1'b1;
        f_addr = $urandom & 32'hFFFF_FFFC;
        drive_reqs();
        bus.io_ready = 1'b0;
        @(negedge clk);
        check("rst.cycle1_read", bus.io_read, 1);
        @(negedge clk);
        check("rst.cycle2_read", bus.io_read, 1);
        rst = 1'b1;
        #1;
        check("rst.io_read",    bus.io_read, 0);
        check("rst.io_addr",    bus.io_addr, 0);
        check("rst.io_size",    bus.io_byte_size, 0);
        check("rst.inst_ready", inst_read_ready, 0);
        f_pend = 1'b0;
        streak_m   = 0;
        last_inst  = '0;
        last_rdata = '0;
        drive_reqs();
        @(negedge clk);
        check_quiet("in_rst");
        bus.io_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_quiet("post_rst");
        end
        bus.io_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        f_pend = 1'b0; d_pend = 1'b0; d_rd_en = 1'b0; d_wr_en = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0; d_size = '0;
        last_inst = '0; last_rdata = '0; streak_m = 0;
        drive_reqs();
        bus.io_ready = 1'b0;
        bus.io_rdata = '0;
        @(negedge clk);
        check_quiet("reset");
        check("reset.io_addr",  bus.io_addr, 0);
        check("reset.io_wdata", bus.io_wdata, 0);
        check("reset.io_size",  bus.io_byte_size, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) run_txn(50, 50);
        for (int i = 0; i < 25; i++) run_txn(100, 100);
        for (int i = 0; i < 10; i++) run_txn(0, 100);
        for (int i = 0; i < 10; i++) run_txn(100, 100);
        reset_mid();
        for (int i = 0; i < 40; i++) run_txn(60, 60);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1);
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Single-master-port arbiter sharing the external io bus between the instruction-fetch port and the data load/store port of the CPU pipeline.
- Sits inside the system bus, between the pipeline's fetch/memory stages and the io_* bus of the CPU top.
- Grants one single-beat transaction at a time, holds the bus stable until io_ready, and returns the response to the winning requester.
- Provides starvation protection for fetch and a per-transaction timeout that reports a bus error.

Parameters:
DATA_W, 32, data/address width (matches MAX_BIT_POS+1)
STARVE_MAX, 4, max consecutive data grants while a fetch is pending (1..15)
TIMEOUT, 255, cycles from grant without io_ready before abort; 0 disables timeout (max 1023)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
inst_read_en  in  1  fetch request, level, held until inst_read_ready
inst_read_addr  in  DATA_W  fetch address
inst_rdata  out  DATA_W  fetched word, valid with inst_read_ready
inst_read_ready  out  1  one-cycle fetch response pulse
read_en  in  1  data load request, level
write_en  in  1  data store request, level
mem_addr  in  DATA_W  data address
wdata  in  DATA_W  store data
byte_size  in  2  access size code
rdata  out  DATA_W  load data, valid with mem_ready
mem_busy  out  1  data request pending, not yet responded
mem_ready  out  1  one-cycle data response pulse
io_addr  out  DATA_W  bus address
io_read  out  1  bus read strobe
io_write  out  1  bus write strobe
burst  out  1  always 0 (single-beat only)
burst_size  out  3  always 0
read_ready  out  1  high while the arbiter accepts read data (io_read active)
io_wdata  out  DATA_W  bus write data
io_byte_size  out  2  bus access size; 2'b10 for fetches
io_rdata  in  DATA_W  bus read data, valid with io_ready
io_ready  in  1  bus completion
bus_err  out  1  one-cycle pulse with the response of a timed-out transaction

Behaviour:
- Clock is clk. Reset rst is asynchronous and active-high. While rst is high:
  - All registered outputs are 0 immediately.
  - State is IDLE; streak and timeout counters are 0.
  - Any in-flight transaction is discarded with no response pulse.
- States and transitions:
  - IDLE: choose a winner.
    - No request: remain in IDLE.
    - Only one request present: grant it.
    - Both present: data wins, unless streak==STARVE_MAX, in which case the fetch wins.
    - Data grant: streak increments, saturating.
    - Fetch grant: streak resets to 0.
  - On grant, latch address, wdata and byte_size (fetch: 2'b10). Go to INST or DATA next cycle.
  - INST/DATA:
    - io_addr, io_wdata and io_byte_size are driven from the latched values and stay stable.
    - io_read is 1 for fetches and loads; io_write is 1 for stores.
    - If read_en and write_en are both high, the store is performed.
    - On io_ready: capture io_rdata (reads only) and go to RESP.
    - Strobes drop to 0 in the RESP cycle.
    - Timeout counter counts from 1 in the first INST/DATA cycle.
    - If counter==TIMEOUT and io_ready=0: abort. Drop strobes, go to RESP with data 0 and bus_err=1.
  - RESP: pulse inst_read_ready or mem_ready for exactly one cycle.
    - Drive inst_rdata/rdata with the captured word; stores and aborts return 0.
    - Go to IDLE.
- Data outputs (inst_rdata, rdata) hold their value until the next response.
- Latency, request sampled in IDLE to ready pulse: 2 + N cycles, where N = INST/DATA cycles including the io_ready cycle. Zero-wait bus gives 3 cycles.
- Requester rule: deassert or replace the request at the clock edge where it samples ready=1. The request is therefore low in the following IDLE cycle, so no re-grant occurs.
- A request dropped before its grant is ignored. A request dropped after its grant still completes and still pulses ready.
- mem_busy = (read_en|write_en) & ~mem_ready (combinational).
- io_ready seen in IDLE or RESP is ignored.
- io_ready on the same cycle as counter==TIMEOUT completes normally; no error.

Test Plan:
1. Fetch only, addr 0x100, io_ready in the 1st bus cycle with io_rdata 0x00000013 -> io_read=1 for 1 cycle, io_byte_size=2'b10; inst_read_ready 3 cycles after request, inst_rdata=0x13.
2. Fetch and load requested in the same cycle, STARVE_MAX=4 -> load granted first (io_addr=load addr), fetch granted next; 5 back-to-back loads with a pending fetch -> fetch wins the 5th arbitration.
3. Store 0xDEADBEEF to 0x2000, byte_size 2'b00, bus waits 3 cycles -> io_write held 3 cycles with stable address/data/size; mem_ready pulse with rdata=0; mem_busy high until that pulse.
4. TIMEOUT=8, bus never responds to a load -> strobes drop after 8 cycles; mem_ready and bus_err pulse together, rdata=0; next request is served normally.
5. rst asserted mid-transaction (cycle 2 of a 5-wait read) -> io_read=0 in the same cycle, no ready pulse; after release a new fetch completes normally.
6. io_ready arrives on the same cycle the counter reaches TIMEOUT (TIMEOUT=4, ready in 4th cycle) -> normal response, bus_err=0, data = io_rdata.
